// File: rtl/uart_image_tx_sequencer.sv
// rtl/uart_image_tx_sequencer.sv - streams one pixel-RAM frame byte by byte into a UART TX engine
module uart_image_tx_sequencer #(
  parameter int         ADDR_W    = 16,
  parameter int         NUM_BYTES = 16384,
  parameter bit         SYNC_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [7:0]        tx_data,
  output logic              tx_wr_en,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   bytes_sent
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    LATCH   = 3'd2,
    SEND    = 3'd3,
    WAIT_HI = 3'd4,
    WAIT_LO = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  state_t state, state_nxt;
  // hdr_pass: the byte in flight is the sync header, so mem_addr must not advance after it.
  logic   hdr_pass;
  // fresh: first LATCH cycle after a RAM read, the only cycle mem_data is known valid.
  logic   fresh;

  assign busy = (state != IDLE);

  // State register; reset drops straight back to IDLE regardless of the TX engine.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and single-cycle strobes; abort outranks everything outside IDLE.
  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    tx_wr_en  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SYNC_EN ? LATCH : READ;
        end
      end
      READ: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          mem_rd_en = 1'b1;
          state_nxt = LATCH;
        end
      end
      LATCH: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (!tx_busy) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          tx_wr_en  = 1'b1;
          state_nxt = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (abort) begin
          state_nxt = DRAIN;
        end else if (tx_busy) begin
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (abort) begin
          state_nxt = DRAIN;
        end else if (!tx_busy) begin
          if (hdr_pass) begin
            state_nxt = READ;
          end else if (mem_addr == LAST_ADDR) begin
            state_nxt = IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: address, byte count and the held TX byte.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr   <= '0;
      tx_data    <= 8'h00;
      bytes_sent <= '0;
      hdr_pass   <= 1'b0;
      fresh      <= 1'b0;
    end else begin
      fresh <= (state == READ) && !abort;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            bytes_sent <= '0;
            mem_addr   <= '0;
            hdr_pass   <= SYNC_EN;
            if (SYNC_EN) begin
              tx_data <= SYNC_BYTE;
            end
          end
        end
        LATCH: begin
          // The header pass arrives here without a read, so fresh is low and tx_data is kept.
          if (fresh) begin
            tx_data <= mem_data;
          end
        end
        WAIT_LO: begin
          if (!abort && !tx_busy) begin
            bytes_sent <= bytes_sent + 1'b1;
            if (hdr_pass) begin
              hdr_pass <= 1'b0;
            end else if (mem_addr != LAST_ADDR) begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The byte already handed to the TX engine still finishes, so it is counted.
          if (!tx_busy) begin
            bytes_sent <= bytes_sent + 1'b1;
            hdr_pass   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_image_tx_sequencer.sv
// tb/tb_uart_image_tx_sequencer.sv - directed bench with behavioural UART TX engine and serial decoder
module tb_uart_image_tx_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] start = 2'b00;
  logic [1:0] abort = 2'b00;
  logic [1:0] ext_busy = 2'b00;
  logic [1:0] mem_rd_en, tx_wr_en, busy, done, tx_busy;
  logic [3:0] mem_addr [2];
  logic [7:0] mem_data [2];
  logic [7:0] tx_data [2];
  logic [4:0] bytes_sent [2];

  logic [7:0] ram [2][4];
  logic [7:0] exp_f [5] = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44};

  logic [1:0] clkdiv = 2'd0;
  logic       clken;
  logic [1:0] eng_busy = 2'b00;
  logic [1:0] line = 2'b11;
  logic [9:0] sh [2];
  logic [3:0] bitn [2];
  logic [3:0] rbit [2] = '{default: 4'd0};
  logic [7:0] rsh [2];
  logic [7:0] rx_buf [2][16];
  logic [7:0] rx_cnt [2] = '{default: 8'd0};
  logic [7:0] wr_cnt [2] = '{default: 8'd0};
  logic [7:0] done_cnt [2] = '{default: 8'd0};

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign tx_busy = eng_busy | ext_busy;
  assign clken   = (clkdiv == 2'd3);

  uart_image_tx_sequencer #(.ADDR_W(4), .NUM_BYTES(4), .SYNC_EN(1'b1), .SYNC_BYTE(8'hAA)) u0 (
    .clk_50m(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
    .mem_rd_en(mem_rd_en[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
    .tx_data(tx_data[0]), .tx_wr_en(tx_wr_en[0]), .tx_busy(tx_busy[0]),
    .busy(busy[0]), .done(done[0]), .bytes_sent(bytes_sent[0]));

  uart_image_tx_sequencer #(.ADDR_W(4), .NUM_BYTES(1), .SYNC_EN(1'b0), .SYNC_BYTE(8'hAA)) u1 (
    .clk_50m(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
    .mem_rd_en(mem_rd_en[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
    .tx_data(tx_data[1]), .tx_wr_en(tx_wr_en[1]), .tx_busy(tx_busy[1]),
    .busy(busy[1]), .done(done[1]), .bytes_sent(bytes_sent[1]));

  // Bit-rate enable: one pulse every 4 clocks.
  always @(posedge clk) clkdiv <= clkdiv + 2'd1;

  // Sync-read pixel RAMs, one per instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_rd_en[i]) mem_data[i] <= ram[i][mem_addr[i][1:0]];
    end
  end

  // 8N1 TX engines; not reset, so a byte in flight always completes.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_wr_en[i] && !eng_busy[i]) begin
        sh[i]       <= {1'b1, tx_data[i], 1'b0};
        bitn[i]     <= 4'd0;
        eng_busy[i] <= 1'b1;
      end else if (eng_busy[i] && clken) begin
        line[i] <= sh[i][0];
        sh[i]   <= {1'b1, sh[i][9:1]};
        if (bitn[i] == 4'd10) eng_busy[i] <= 1'b0;
        else bitn[i] <= bitn[i] + 4'd1;
      end
    end
  end

  // Serial decoders sampling once per bit on clken.
  always @(posedge clk) begin
    if (clken) begin
      for (int i = 0; i < 2; i++) begin
        if (rbit[i] == 4'd0) begin
          if (!line[i]) rbit[i] <= 4'd1;
        end else if (rbit[i] <= 4'd8) begin
          rsh[i]  <= {line[i], rsh[i][7:1]};
          rbit[i] <= rbit[i] + 4'd1;
        end else begin
          if (line[i]) begin
            rx_buf[i][rx_cnt[i][3:0]] <= rsh[i];
            rx_cnt[i] <= rx_cnt[i] + 8'd1;
          end
          rbit[i] <= 4'd0;
        end
      end
    end
  end

  // Strobe counters.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (tx_wr_en[i]) wr_cnt[i] <= wr_cnt[i] + 8'd1;
      if (done[i]) done_cnt[i] <= done_cnt[i] + 8'd1;
    end
  end

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, output int k);
    k = 0;
    while ((busy[i] || eng_busy[i]) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL rst_busy: got %0b want 0", busy[0]); end
    tests++; if (mem_rd_en[0] !== 1'b0) begin fails++; $display("FAIL rst_rd_en: got %0b want 0", mem_rd_en[0]); end
    tests++; if (mem_addr[0] !== 4'd0) begin fails++; $display("FAIL rst_addr: got %0h want 0", mem_addr[0]); end
    tests++; if (tx_data[0] !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %0h want 0", tx_data[0]); end
    tests++; if ({tx_wr_en[0], done[0]} !== 2'b00) begin fails++; $display("FAIL rst_strobes: got %0b want 00", {tx_wr_en[0], done[0]}); end
    tests++; if (bytes_sent[0] !== 5'd0) begin fails++; $display("FAIL rst_bytes: got %0d want 0", bytes_sent[0]); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_sync();
    logic [7:0] rb, wb, db;
    int k;
    rb = rx_cnt[0]; wb = wr_cnt[0]; db = done_cnt[0];
    pulse_start(0);
    wait_idle(0, k);
    tests++; if (k >= 3000) begin fails++; $display("FAIL f1_timeout: got %0d cycles want < 3000", k); end
    tests++; if (8'(rx_cnt[0] - rb) !== 8'd5) begin fails++; $display("FAIL f1_rx_count: got %0d want 5", 8'(rx_cnt[0] - rb)); end
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (rx_buf[0][4'(rb + j)] !== exp_f[j]) begin
        fails++; $display("FAIL f1_byte%0d: got %0h want %0h", j, rx_buf[0][4'(rb + j)], exp_f[j]);
      end
    end
    tests++; if (8'(wr_cnt[0] - wb) !== 8'd5) begin fails++; $display("FAIL f1_wr_en: got %0d want 5", 8'(wr_cnt[0] - wb)); end
    tests++; if (8'(done_cnt[0] - db) !== 8'd1) begin fails++; $display("FAIL f1_done: got %0d want 1", 8'(done_cnt[0] - db)); end
    tests++; if (bytes_sent[0] !== 5'd5) begin fails++; $display("FAIL f1_bytes_sent: got %0d want 5", bytes_sent[0]); end
    tests++; if (mem_addr[0] !== 4'd3) begin fails++; $display("FAIL f1_addr_nowrap: got %0d want 3", mem_addr[0]); end
  endtask

  task automatic test_single_nosync();
    logic [7:0] rb, wb, db;
    int k;
    rb = rx_cnt[1]; wb = wr_cnt[1]; db = done_cnt[1];
    pulse_start(1);
    wait_idle(1, k);
    tests++; if (k >= 3000) begin fails++; $display("FAIL f2_timeout: got %0d cycles want < 3000", k); end
    tests++; if (8'(wr_cnt[1] - wb) !== 8'd1) begin fails++; $display("FAIL f2_wr_en: got %0d want 1", 8'(wr_cnt[1] - wb)); end
    tests++; if (8'(rx_cnt[1] - rb) !== 8'd1) begin fails++; $display("FAIL f2_rx_count: got %0d want 1", 8'(rx_cnt[1] - rb)); end
    tests++; if (rx_buf[1][rb[3:0]] !== 8'h5A) begin fails++; $display("FAIL f2_byte: got %0h want 5a", rx_buf[1][rb[3:0]]); end
    tests++; if (8'(done_cnt[1] - db) !== 8'd1) begin fails++; $display("FAIL f2_done: got %0d want 1", 8'(done_cnt[1] - db)); end
    tests++; if (busy[1] !== 1'b0) begin fails++; $display("FAIL f2_busy: got %0b want 0", busy[1]); end
    tests++; if (bytes_sent[1] !== 5'd1) begin fails++; $display("FAIL f2_bytes_sent: got %0d want 1", bytes_sent[1]); end
  endtask

  task automatic test_extra_start();
    logic [7:0] rb, db;
    int k;
    rb = rx_cnt[0]; db = done_cnt[0];
    pulse_start(0);
    k = 0;
    while ((busy[0] || eng_busy[0]) && k < 3000) begin
      start[0] = (k == 40 || k == 81 || k == 150);
      @(negedge clk);
      k++;
    end
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (k >= 3000) begin fails++; $display("FAIL f3_timeout: got %0d cycles want < 3000", k); end
    tests++; if (8'(rx_cnt[0] - rb) !== 8'd5) begin fails++; $display("FAIL f3_rx_count: got %0d want 5", 8'(rx_cnt[0] - rb)); end
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (rx_buf[0][4'(rb + j)] !== exp_f[j]) begin
        fails++; $display("FAIL f3_byte%0d: got %0h want %0h", j, rx_buf[0][4'(rb + j)], exp_f[j]);
      end
    end
    tests++; if (8'(done_cnt[0] - db) !== 8'd1) begin fails++; $display("FAIL f3_done: got %0d want 1", 8'(done_cnt[0] - db)); end
  endtask

  task automatic test_abort();
    logic [7:0] rb, wb, db;
    int k;
    start[0] = 1'b1; abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0; abort[0] = 1'b0;
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL f4_start_abort_idle: got busy %0b want 0", busy[0]); end
    rb = rx_cnt[0]; wb = wr_cnt[0]; db = done_cnt[0];
    pulse_start(0);
    k = 0;
    while (8'(wr_cnt[0] - wb) != 8'd2 && k < 1000) begin @(negedge clk); k++; end
    tests++; if (k >= 1000) begin fails++; $display("FAIL f4_wait_byte2: got %0d cycles want < 1000", k); end
    repeat (5) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    k = 0;
    while (busy[0] && k < 1000) begin @(negedge clk); k++; end
    tests++; if (eng_busy[0] !== 1'b0) begin fails++; $display("FAIL f4_idle_before_drain: tx busy %0b at idle want 0", eng_busy[0]); end
    repeat (100) @(negedge clk);
    tests++; if (8'(wr_cnt[0] - wb) !== 8'd2) begin fails++; $display("FAIL f4_wr_en: got %0d want 2", 8'(wr_cnt[0] - wb)); end
    tests++; if (8'(rx_cnt[0] - rb) !== 8'd2) begin fails++; $display("FAIL f4_rx_count: got %0d want 2", 8'(rx_cnt[0] - rb)); end
    tests++; if (rx_buf[0][4'(rb + 1)] !== 8'h11) begin fails++; $display("FAIL f4_byte2: got %0h want 11", rx_buf[0][4'(rb + 1)]); end
    tests++; if (8'(done_cnt[0] - db) !== 8'd0) begin fails++; $display("FAIL f4_no_done: got %0d want 0", 8'(done_cnt[0] - db)); end
    tests++; if (bytes_sent[0] !== 5'd2) begin fails++; $display("FAIL f4_bytes_sent: got %0d want 2", bytes_sent[0]); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL f4_busy: got %0b want 0", busy[0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] rb, db, wb;
    int k;
    wb = wr_cnt[0];
    pulse_start(0);
    k = 0;
    while (8'(wr_cnt[0] - wb) != 8'd3 && k < 1000) begin @(negedge clk); k++; end
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy[0], mem_rd_en[0], tx_wr_en[0], done[0], mem_addr[0], tx_data[0], bytes_sent[0]} !== 21'd0) begin
      fails++; $display("FAIL f5_async_reset: busy %0b addr %0h data %0h bytes %0d want all 0",
                        busy[0], mem_addr[0], tx_data[0], bytes_sent[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    while (eng_busy[0] && k < 1000) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    rb = rx_cnt[0]; db = done_cnt[0];
    pulse_start(0);
    wait_idle(0, k);
    tests++; if (8'(rx_cnt[0] - rb) !== 8'd5) begin fails++; $display("FAIL f5_rx_count: got %0d want 5", 8'(rx_cnt[0] - rb)); end
    for (int j = 0; j < 5; j++) begin
      tests++;
      if (rx_buf[0][4'(rb + j)] !== exp_f[j]) begin
        fails++; $display("FAIL f5_byte%0d: got %0h want %0h", j, rx_buf[0][4'(rb + j)], exp_f[j]);
      end
    end
    tests++; if (8'(done_cnt[0] - db) !== 8'd1) begin fails++; $display("FAIL f5_done: got %0d want 1", 8'(done_cnt[0] - db)); end
  endtask

  task automatic test_hold_busy();
    logic [7:0] rb, wb;
    int k;
    rb = rx_cnt[0]; wb = wr_cnt[0];
    ext_busy[0] = 1'b1;
    pulse_start(0);
    repeat (30) @(negedge clk);
    tests++; if (8'(wr_cnt[0] - wb) !== 8'd0) begin fails++; $display("FAIL f6_wr_while_busy: got %0d want 0", 8'(wr_cnt[0] - wb)); end
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL f6_busy_latch: got %0b want 1", busy[0]); end
    ext_busy[0] = 1'b0;
    repeat (10) @(negedge clk);
    tests++; if (8'(wr_cnt[0] - wb) !== 8'd1) begin fails++; $display("FAIL f6_single_wr: got %0d want 1", 8'(wr_cnt[0] - wb)); end
    wait_idle(0, k);
    tests++; if (8'(wr_cnt[0] - wb) !== 8'd5) begin fails++; $display("FAIL f6_wr_total: got %0d want 5", 8'(wr_cnt[0] - wb)); end
    tests++; if (rx_buf[0][4'(rb + 4)] !== 8'h44) begin fails++; $display("FAIL f6_last_byte: got %0h want 44", rx_buf[0][4'(rb + 4)]); end
  endtask

  initial begin
    ram[0][0] = 8'h11; ram[0][1] = 8'h22; ram[0][2] = 8'h33; ram[0][3] = 8'h44;
    ram[1][0] = 8'h5A; ram[1][1] = 8'h00; ram[1][2] = 8'h00; ram[1][3] = 8'h00;
    test_reset();
    test_frame_sync();
    test_single_nosync();
    test_extra_start();
    test_abort();
    test_reset_mid_frame();
    test_hold_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
